// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter: source encodings, the "no redirect" pc,
// the default ROB id width and the round-robin step helper.
package cdb_arbiter_pkg;

  localparam int CDB_ROB_W   = 4;
  localparam int CDB_NUM_SRC = 3;

  localparam logic [31:0] CDB_NO_REDIRECT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    CDB_SRC_ALU = 2'd0,
    CDB_SRC_LD  = 2'd1,
    CDB_SRC_ST  = 2'd2
  } cdb_src_e;

  // Next source in round-robin order, wrapping ST back to ALU.
  function automatic cdb_src_e cdb_rr_inc(input cdb_src_e s);
    case (s)
      CDB_SRC_ALU: return CDB_SRC_LD;
      CDB_SRC_LD:  return CDB_SRC_ST;
      default:     return CDB_SRC_ALU;
    endcase
  endfunction

endpackage

// File: rtl/cdb_arbiter_src_fifo.sv
// cdb_src_fifo: per-producer result queue with wrap-bit pointers; flush empties it,
// en low freezes it. Full/empty are derived from pointers only.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A push into a full queue is dropped; flush outranks both push and pop.
  assign do_push = en_i && !flush_i && push_i && !full_o;
  assign do_pop  = en_i && !flush_i && pop_i  && !empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (en_i && flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone say which slots hold live data,
  // so resetting the array would only cost flops and reset routing.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

  assign head_o = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: three producer FIFOs feeding one registered CDB broadcast via round-robin.
// Optional macro CDB_BYPASS_EN lets an empty, granted source's input skip its FIFO.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_W      = CDB_ROB_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             alu_valid,
  input  logic [31:0]      alu_value,
  input  logic [ROB_W-1:0] alu_robid,
  input  logic [31:0]      alu_topc,
  output logic             alu_ready,
  input  logic             ld_valid,
  input  logic [31:0]      ld_value,
  input  logic [ROB_W-1:0] ld_robid,
  output logic             ld_ready,
  input  logic             st_valid,
  input  logic [ROB_W-1:0] st_robid,
  output logic             st_ready,
  output logic             cdb_valid,
  output logic [1:0]       cdb_src,
  output logic [31:0]      cdb_value,
  output logic [ROB_W-1:0] cdb_robid,
  output logic [31:0]      cdb_topc
);

  localparam int ALU_W = 64 + ROB_W;
  localparam int LD_W  = 32 + ROB_W;

  logic [2:0]       in_valid, empty, full, byp, avail, pop, push;
  logic [ALU_W-1:0] alu_head;
  logic [LD_W-1:0]  ld_head;
  logic [ROB_W-1:0] st_head;

  cdb_src_e         rr_q, rr_d, src_q, src_d, grant, cand;
  logic             found, use_in;
  logic             valid_q, valid_d;
  logic [31:0]      value_q, value_d, topc_q, topc_d, sel_value, sel_topc;
  logic [ROB_W-1:0] robid_q, robid_d, sel_robid;

  assign in_valid = {st_valid, ld_valid, alu_valid};

  cdb_src_fifo #(.W(ALU_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk(clk), .rst_n(rst), .en_i(rdy), .flush_i(flush),
    .push_i(push[CDB_SRC_ALU]), .push_data_i({alu_topc, alu_value, alu_robid}),
    .pop_i(pop[CDB_SRC_ALU]), .head_o(alu_head),
    .empty_o(empty[CDB_SRC_ALU]), .full_o(full[CDB_SRC_ALU])
  );

  cdb_src_fifo #(.W(LD_W), .DEPTH(FIFO_DEPTH)) u_ld_fifo (
    .clk(clk), .rst_n(rst), .en_i(rdy), .flush_i(flush),
    .push_i(push[CDB_SRC_LD]), .push_data_i({ld_value, ld_robid}),
    .pop_i(pop[CDB_SRC_LD]), .head_o(ld_head),
    .empty_o(empty[CDB_SRC_LD]), .full_o(full[CDB_SRC_LD])
  );

  cdb_src_fifo #(.W(ROB_W), .DEPTH(FIFO_DEPTH)) u_st_fifo (
    .clk(clk), .rst_n(rst), .en_i(rdy), .flush_i(flush),
    .push_i(push[CDB_SRC_ST]), .push_data_i(st_robid),
    .pop_i(pop[CDB_SRC_ST]), .head_o(st_head),
    .empty_o(empty[CDB_SRC_ST]), .full_o(full[CDB_SRC_ST])
  );

  assign alu_ready = !full[CDB_SRC_ALU];
  assign ld_ready  = !full[CDB_SRC_LD];
  assign st_ready  = !full[CDB_SRC_ST];

`ifdef CDB_BYPASS_EN
  assign byp = in_valid & empty;
`else
  assign byp = '0;
`endif

  assign avail = ~empty | byp;

  // NOTE: combinational blocks assign every output a default first, so no path
  // through the logic leaves a signal unassigned and a latch is never inferred.
  always_comb begin
    found = 1'b0;
    grant = rr_q;
    cand  = rr_q;
    for (int k = 0; k < CDB_NUM_SRC; k++) begin
      if (!found && avail[cand]) begin
        found = 1'b1;
        grant = cand;
      end
      cand = cdb_rr_inc(cand);
    end
  end

  // A granted source with an empty FIFO can only be a bypass; a queued head always wins.
  assign use_in = found && empty[grant];
  assign pop    = (found && !empty[grant]) ? (3'b001 << grant) : 3'b000;
  assign push   = in_valid & ~(use_in ? (3'b001 << grant) : 3'b000);

  always_comb begin
    sel_value = '0;
    sel_robid = '0;
    sel_topc  = CDB_NO_REDIRECT;
    case (grant)
      CDB_SRC_ALU: {sel_topc, sel_value, sel_robid} =
                     use_in ? {alu_topc, alu_value, alu_robid} : alu_head;
      CDB_SRC_LD:  {sel_value, sel_robid} = use_in ? {ld_value, ld_robid} : ld_head;
      CDB_SRC_ST:  sel_robid = use_in ? st_robid : st_head;
      default: ;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    src_d   = src_q;
    value_d = value_q;
    robid_d = robid_q;
    topc_d  = topc_q;
    rr_d    = rr_q;
    if (rdy) begin
      if (flush) begin
        valid_d = 1'b0;
      end else if (found) begin
        valid_d = 1'b1;
        src_d   = grant;
        value_d = sel_value;
        robid_d = sel_robid;
        topc_d  = sel_topc;
        rr_d    = cdb_rr_inc(grant);
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      src_q   <= CDB_SRC_ALU;
      value_q <= '0;
      robid_q <= '0;
      topc_q  <= CDB_NO_REDIRECT;
      rr_q    <= CDB_SRC_ALU;
    end else begin
      valid_q <= valid_d;
      src_q   <= src_d;
      value_q <= value_d;
      robid_q <= robid_d;
      topc_q  <= topc_d;
      rr_q    <= rr_d;
    end
  end

  assign cdb_valid = valid_q;
  assign cdb_src   = src_q;
  assign cdb_value = value_q;
  assign cdb_robid = robid_q;
  assign cdb_topc  = topc_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model plus directed
// scenarios and randomized traffic. Honours CDB_BYPASS_EN in the model.
module tb_cdb_arbiter;

  localparam int ROB_W = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst, rdy, flush;
  logic             alu_valid, ld_valid, st_valid;
  logic [31:0]      alu_value, alu_topc, ld_value;
  logic [ROB_W-1:0] alu_robid, ld_robid, st_robid;
  logic             alu_ready, ld_ready, st_ready;
  logic             cdb_valid;
  logic [1:0]       cdb_src;
  logic [31:0]      cdb_value, cdb_topc;
  logic [ROB_W-1:0] cdb_robid;

  int errors = 0;
  int checks = 0;

  cdb_arbiter #(.ROB_W(ROB_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alu_valid(alu_valid), .alu_value(alu_value), .alu_robid(alu_robid),
    .alu_topc(alu_topc), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_value(ld_value), .ld_robid(ld_robid), .ld_ready(ld_ready),
    .st_valid(st_valid), .st_robid(st_robid), .st_ready(st_ready),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_value(cdb_value),
    .cdb_robid(cdb_robid), .cdb_topc(cdb_topc)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0]      value;
    logic [ROB_W-1:0] robid;
    logic [31:0]      topc;
  } ent_t;

  ent_t q[3][$];
  int   m_rr;
  bit   m_valid;
  int   m_src;
  logic [31:0]      m_value, m_topc;
  logic [ROB_W-1:0] m_robid;

`ifdef CDB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int   sz[3];
  bit   v[3];
  bit   bypassed[3];
  ent_t inp[3];
  int   g;
  ent_t e;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < 3; s++) q[s].delete();
      m_rr = 0; m_valid = 0; m_src = 0; m_value = 0; m_robid = 0; m_topc = 32'hFFFF_FFFF;
    end else if (rdy) begin
      if (flush) begin
        for (int s = 0; s < 3; s++) q[s].delete();
        m_valid = 0;
      end else begin
        v[0] = alu_valid; v[1] = ld_valid; v[2] = st_valid;
        inp[0] = '{alu_value, alu_robid, alu_topc};
        inp[1] = '{ld_value, ld_robid, 32'hFFFF_FFFF};
        inp[2] = '{32'h0, st_robid, 32'hFFFF_FFFF};
        for (int s = 0; s < 3; s++) begin sz[s] = q[s].size(); bypassed[s] = 0; end
        g = -1;
        for (int k = 0; k < 3; k++) begin
          int s;
          s = (m_rr + k) % 3;
          if (g < 0 && (sz[s] > 0 || (BYPASS && v[s]))) g = s;
        end
        if (g >= 0) begin
          if (sz[g] > 0) e = q[g].pop_front();
          else begin e = inp[g]; bypassed[g] = 1; end
          m_valid = 1; m_src = g; m_value = e.value; m_robid = e.robid; m_topc = e.topc;
          m_rr = (g + 1) % 3;
        end else begin
          m_valid = 0;
        end
        for (int s = 0; s < 3; s++)
          if (v[s] && !bypassed[s] && sz[s] < DEPTH) q[s].push_back(inp[s]);
      end
    end
  end

  always @(posedge clk) begin
    if (rst && rdy && !flush)
      assert (!(alu_valid && !alu_ready) && !(ld_valid && !ld_ready) && !(st_valid && !st_ready))
        else $error("producer asserted valid while its ready was low");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("cdb_valid", cdb_valid, m_valid);
    check("cdb_src",   cdb_src,   m_src[1:0]);
    check("cdb_value", cdb_value, m_value);
    check("cdb_robid", cdb_robid, m_robid);
    check("cdb_topc",  cdb_topc,  m_topc);
    check("alu_ready", alu_ready, q[0].size() < DEPTH);
    check("ld_ready",  ld_ready,  q[1].size() < DEPTH);
    check("st_ready",  st_ready,  q[2].size() < DEPTH);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    rdy = 1; flush = 0;
    alu_valid = 0; ld_valid = 0; st_valid = 0;
    alu_value = 0; alu_robid = 0; alu_topc = 32'hFFFF_FFFF;
    ld_value = 0; ld_robid = 0; st_robid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    #1 rst = 0;
    #2 rst = 1;
    #1;
    check("rst_valid", cdb_valid, 1'b0);
    check("rst_topc", cdb_topc, 32'hFFFF_FFFF);
  endtask

  int seq[$];
  int first_t, last_t;
  bit saw_full;
  bit got_it;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0;
    idle_inputs();
    #12 rst = 1;
    @(negedge clk);
    compare_all();

    // Single ALU result
    alu_valid = 1; alu_value = 32'h1234; alu_robid = 3; alu_topc = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
`ifndef CDB_BYPASS_EN
    check("single_e0_valid", cdb_valid, 1'b0);
    tick();
`endif
    check("single_valid", cdb_valid, 1'b1);
    check("single_src",   cdb_src, 2'd0);
    check("single_value", cdb_value, 32'h1234);
    check("single_robid", cdb_robid, 4'd3);
    check("single_topc",  cdb_topc, 32'hFFFF_FFFF);
    tick();
    check("single_once", cdb_valid, 1'b0);

    // Fairness: three of each pushed in the same cycles
    do_reset();
    seq.delete(); first_t = -1; last_t = -1;
    for (int c = 0; c < 20; c++) begin
      if (c < 3) begin
        alu_valid = 1; alu_value = 32'hA0 + c; alu_robid = 4'(c); alu_topc = 32'h100 + c;
        ld_valid  = 1; ld_value  = 32'hB0 + c; ld_robid  = 4'(4 + c);
        st_valid  = 1; st_robid  = 4'(8 + c);
      end else idle_inputs();
      tick();
      if (cdb_valid && seq.size() < 9) begin
        seq.push_back(int'(cdb_src));
        if (first_t < 0) first_t = c;
        last_t = c;
      end
    end
    check("fair_count", seq.size(), 9);
    check("fair_nogap", last_t - first_t, 8);
    for (int i = 0; i < seq.size(); i++) check("fair_order", seq[i], i % 3);

    // Full ALU FIFO under competing load/store traffic
    do_reset();
    saw_full = 0;
    for (int c = 0; c < 14; c++) begin
      alu_valid = (q[0].size() < DEPTH); alu_value = 32'hC00 + c;
      alu_robid = 4'(c); alu_topc = 32'h2000 + c;
      ld_valid = (q[1].size() < DEPTH); ld_value = 32'hD00 + c; ld_robid = 4'(c + 1);
      st_valid = (q[2].size() < DEPTH); st_robid = 4'(c + 2);
      tick();
      if (!alu_ready) saw_full = 1;
    end
    check("full_seen", saw_full, 1'b1);
    idle_inputs();
    for (int c = 0; c < 16; c++) tick();
    check("full_drained_alu", alu_ready, 1'b1);

    // Flush mid-stream
    do_reset();
    for (int c = 0; c < 2; c++) begin
      alu_valid = 1; alu_value = 32'hE0 + c; alu_robid = 4'(c);
      ld_valid = 1; ld_value = 32'hF0 + c; ld_robid = 4'(c + 6);
      tick();
    end
    flush = 1; st_valid = 1; st_robid = 4'd9;
    tick();
    check("flush_valid", cdb_valid, 1'b0);
    check("flush_alu_ready", alu_ready, 1'b1);
    check("flush_ld_ready", ld_ready, 1'b1);
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      tick();
      check("flush_no_stale", cdb_valid, 1'b0);
    end

    // rdy low holds state
    do_reset();
    ld_valid = 1; ld_value = 32'h5555; ld_robid = 4'd5;
    tick();
    idle_inputs();
    rdy = 0;
    ld_valid = 1; ld_robid = 4'd7;
    for (int c = 0; c < 5; c++) begin
      tick();
`ifndef CDB_BYPASS_EN
      check("rdy_hold", cdb_valid, 1'b0);
`endif
    end
    idle_inputs();
    got_it = 0;
    for (int c = 0; c < 4 && !got_it; c++) begin
      tick();
      if (cdb_valid) got_it = 1;
    end
    check("rdy_release_seen", got_it, 1'b1);
    check("rdy_release_robid", cdb_robid, 4'd5);
    check("rdy_release_src", cdb_src, 2'd1);

    // Asynchronous reset in the middle of a broadcast
    do_reset();
    alu_valid = 1; alu_value = 32'h77; alu_robid = 4'd2; alu_topc = 32'h400;
    tick();
    idle_inputs();
`ifndef CDB_BYPASS_EN
    tick();
`endif
    check("arst_pre_valid", cdb_valid, 1'b1);
    #1 rst = 0;
    #1;
    check("arst_valid", cdb_valid, 1'b0);
    check("arst_topc", cdb_topc, 32'hFFFF_FFFF);
    check("arst_value", cdb_value, 32'h0);
    #1 rst = 1;
    tick();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 29) == 0);
      alu_valid = $urandom_range(0, 1) && (q[0].size() < DEPTH);
      ld_valid  = $urandom_range(0, 1) && (q[1].size() < DEPTH);
      st_valid  = $urandom_range(0, 1) && (q[2].size() < DEPTH);
      alu_value = $urandom; alu_robid = 4'($urandom);
      alu_topc  = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom;
      ld_value  = $urandom; ld_robid = 4'($urandom);
      st_robid  = 4'($urandom);
      tick();
    end
    idle_inputs();
    for (int c = 0; c < 16; c++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among the three result producers: ALU, load unit and store unit.
- The CDB is the write-back path into the reorder buffer and the reservation stations.
- Each producer has its own small result FIFO. A round-robin scheduler grants one producer per cycle and drives one registered CDB broadcast.
- Sits between the execution units and the reorder buffer / reservation stations. Misprediction flush empties all queued results.

Parameters:
- ROB_W, 4, width of reorder-buffer ids (ROB size = 2^ROB_W).
- FIFO_DEPTH, 4, entries per producer FIFO; power of two, >= 2.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- rdy  input  1  global enable; when low, all state holds.
- flush  input  1  misprediction flush from the reorder buffer.
- alu_valid  input  1  ALU result present.
- alu_value  input  32  ALU result.
- alu_robid  input  ROB_W  destination ROB id.
- alu_topc  input  32  redirect target; all-ones = pc+4.
- alu_ready  output  1  ALU FIFO not full.
- ld_valid  input  1  load result present.
- ld_value  input  32  loaded data.
- ld_robid  input  ROB_W  ROB id.
- ld_ready  output  1  load FIFO not full.
- st_valid  input  1  store address/data ready.
- st_robid  input  ROB_W  ROB id.
- st_ready  output  1  store FIFO not full.
- cdb_valid  output  1  broadcast valid this cycle.
- cdb_src  output  2  granted source: 0 ALU, 1 load, 2 store.
- cdb_value  output  32  broadcast value.
- cdb_robid  output  ROB_W  broadcast ROB id.
- cdb_topc  output  32  broadcast target pc.

Behaviour:
- Reset (rst=0, asynchronous):
  - All FIFOs empty.
  - Round-robin pointer rr=0.
  - cdb_valid=0, cdb_src=0, cdb_value=0, cdb_robid=0, cdb_topc=32'hFFFFFFFF.
  - All readies=1.
- rdy=0: all registers hold and inputs are ignored. Readies still reflect FIFO state.
- Push:
  - On an edge with rdy=1, flush=0 and x_valid=1, the entry is written to FIFO x.
  - Producers must not assert x_valid while x_ready=0. A bench assertion checks this; the RTL drops such an entry.
- Readies: x_ready = !full(x). Computed from occupancy only; a same-cycle pop does not free space.
- Arbitration: at each enabled edge, scan sources rr, rr+1, rr+2 (mod 3). The first non-empty FIFO head is popped into the CDB registers. cdb_valid<=1, and rr <= (grant+1) mod 3.
- No non-empty FIFO: cdb_valid<=0. Payload registers hold and rr holds.
- Store entries broadcast cdb_value=0 and cdb_topc=32'hFFFFFFFF.
- Load entries broadcast cdb_topc=32'hFFFFFFFF.
- Latency: an input accepted at edge E0 appears on the CDB after edge E1 at the earliest, i.e. 2 cycles.
- Throughput: one broadcast per enabled cycle.
- Flush (rdy=1):
  - At the edge, all FIFOs are emptied and cdb_valid<=0.
  - Inputs in the flush cycle are discarded. rr holds.
  - Flush has priority over push and pop.
- Pointer wrap: FIFO read/write pointers wrap modulo FIFO_DEPTH. An extra wrap bit distinguishes full from empty.
- Simultaneous push and pop on the same FIFO in one edge is legal: count is unchanged and order is preserved.

Optional Feature:
- Macro CDB_BYPASS_EN.
- Defined: when the granted-by-scan source's FIFO is empty and its x_valid=1 at the edge, the input goes directly into the CDB registers (latency 1 cycle).
  - The scan treats "FIFO empty but x_valid" as non-empty for that source.
  - FIFO entries always win over the same source's bypass, which preserves order.
- Undefined: strict 2-cycle path through the FIFO.

Decomposition:
- Shared package/include holds:
  - source encodings CDB_SRC_ALU=0, CDB_SRC_LD=1, CDB_SRC_ST=2;
  - the all-ones "no redirect" constant;
  - the ROB id width macro.
- One natural sub-module: cdb_src_fifo, parameterised by payload width and depth, instantiated three times. Store instance payload = ROB id only.

Test Plan:
- Single ALU result: alu_valid=1, value=0x1234, robid=3, one cycle → 2 cycles later cdb_valid=1, src=0, value=0x1234, robid=3, topc=0xFFFFFFFF for exactly one cycle.
- Fairness: ALU, load and store each push 3 entries in the same cycles → CDB order is ALU, LD, ST, ALU, LD, ST, ALU, LD, ST over 9 consecutive cycles with no gaps.
- Full: push 4 ALU entries with the CDB blocked by continuous load traffic → alu_ready=0 after the 4th push. No entry is lost, and all 4 appear in FIFO order.
- Flush mid-stream: queue 2 ALU and 2 load entries, assert flush for one cycle → cdb_valid=0 the next cycle, readies=1, and no stale broadcast ever appears.
- rdy low: queue one load (robid=5), hold rdy=0 for 5 cycles → no broadcast. After rdy rises, the broadcast appears with robid=5.
- Async reset: drop rst mid-broadcast → cdb_valid goes to 0 immediately, before the next edge. With CDB_BYPASS_EN, a single ALU push broadcasts after 1 cycle.
